vga_timing_gen: RTL and testbench

//  Runtime-programmable raster timing generator, generalising the fixed 1080p/FAST_SIM timing constants.

---
 rtl/vga_timing_gen.sv | 239 +++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator.
// Live timing drives two raster counters. New timings are offered over a
// valid/ready handshake, validated, parked in a single-entry shadow register,
// and copied into the live set only at a frame wrap or while the raster is
// disabled, so a mode change never produces a partial line or frame.
module vga_timing_gen #(
    parameter int unsigned CW    = 12,
    parameter int unsigned H_ACT = 1920,
    parameter int unsigned H_FP  = 88,
    parameter int unsigned H_SYN = 44,
    parameter int unsigned H_BP  = 148,
    parameter int unsigned V_ACT = 1080,
    parameter int unsigned V_FP  = 4,
    parameter int unsigned V_SYN = 5,
    parameter int unsigned V_BP  = 36,
    parameter int unsigned POL   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            cfg_valid_i,
    output logic            cfg_ready_o,
    input  logic [4*CW-1:0] cfg_h_i,
    input  logic [4*CW-1:0] cfg_v_i,
    input  logic [1:0]      cfg_pol_i,
    output logic            cfg_err_o,
    output logic            cfg_pend_o,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            de_o,
    output logic [CW-1:0]   x_o,
    output logic [CW-1:0]   y_o,
    output logic            sof_o,
    output logic            eol_o
);

    // One axis of timing; field order matches the cfg_*_i packing (act in MSBs).
    typedef struct packed {
        logic [CW-1:0] act;
        logic [CW-1:0] fp;
        logic [CW-1:0] syn;
        logic [CW-1:0] bp;
    } axis_t;

    // Two guard bits so a sum of four CW-bit fields can never overflow.
    typedef logic [CW+1:0] wide_t;

    localparam axis_t H_DEF = '{act: CW'(H_ACT), fp: CW'(H_FP), syn: CW'(H_SYN), bp: CW'(H_BP)};
    localparam axis_t V_DEF = '{act: CW'(V_ACT), fp: CW'(V_FP), syn: CW'(V_SYN), bp: CW'(V_BP)};
    localparam logic       POL_B   = (POL != 0);
    localparam logic [1:0] POL_DEF = {POL_B, POL_B};
    localparam wide_t      TOT_MAX = wide_t'(1) << CW;

    function automatic wide_t total(input axis_t a);
        return wide_t'(a.act) + wide_t'(a.fp) + wide_t'(a.syn) + wide_t'(a.bp);
    endfunction

    // A timing is usable when both axes have a visible area, a sync pulse,
    // and a total that still fits the CW-bit counters.
    function automatic logic cfg_ok(input axis_t h, input axis_t v);
        logic zero_field;
        logic too_long;
        zero_field = (h.act == '0) || (h.syn == '0) || (v.act == '0) || (v.syn == '0);
        too_long   = (total(h) > TOT_MAX) || (total(v) > TOT_MAX);
        return !(zero_field || too_long);
    endfunction

    // Live and shadow timing
    axis_t         live_h_q;
    axis_t         live_v_q;
    logic [1:0]    live_pol_q;
    axis_t         sh_h_q;
    axis_t         sh_v_q;
    logic [1:0]    sh_pol_q;
    logic          sh_vld_q;
    logic          err_q;

    // Raster counters
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    // Registered outputs
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    // Decode of the live timing against the current counter position
    axis_t         cfg_h;
    axis_t         cfg_v;
    wide_t         h_w, v_w;
    wide_t         h_last, v_last;
    wide_t         h_sb, h_se, v_sb, v_se;
    logic          h_end, v_end;
    logic          frame_wrap;
    logic          accept;
    logic          cfg_bad;
    logic          apply;
    logic          in_hact, in_vact;
    logic          in_hsync, in_vsync;

    assign cfg_h = axis_t'(cfg_h_i);
    assign cfg_v = axis_t'(cfg_v_i);

    // Position decode, handshake qualification and apply condition.
    always_comb begin
        h_w        = wide_t'(h_q);
        v_w        = wide_t'(v_q);
        h_last     = total(live_h_q) - wide_t'(1);
        v_last     = total(live_v_q) - wide_t'(1);
        h_sb       = wide_t'(live_h_q.act) + wide_t'(live_h_q.fp);
        h_se       = h_sb + wide_t'(live_h_q.syn);
        v_sb       = wide_t'(live_v_q.act) + wide_t'(live_v_q.fp);
        v_se       = v_sb + wide_t'(live_v_q.syn);
        h_end      = (h_w == h_last);
        v_end      = (v_w == v_last);
        in_hact    = (h_w < wide_t'(live_h_q.act));
        in_vact    = (v_w < wide_t'(live_v_q.act));
        in_hsync   = (h_w >= h_sb) && (h_w < h_se);
        in_vsync   = (v_w >= v_sb) && (v_w < v_se);
        frame_wrap = en_i && h_end && v_end;
        accept     = cfg_valid_i && !sh_vld_q;
        cfg_bad    = !cfg_ok(cfg_h, cfg_v);
        // Accept implies an empty shadow, so accept and apply never coincide;
        // a config taken on the wrap cycle waits for the following wrap.
        apply      = sh_vld_q && (!en_i || frame_wrap);
    end

    // Shadow capture on accept, shadow-to-live transfer on apply, reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_h_q   <= H_DEF;
            live_v_q   <= V_DEF;
            live_pol_q <= POL_DEF;
            sh_h_q     <= '0;
            sh_v_q     <= '0;
            sh_pol_q   <= '0;
            sh_vld_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= accept && cfg_bad;
            if (apply) begin
                live_h_q   <= sh_h_q;
                live_v_q   <= sh_v_q;
                live_pol_q <= sh_pol_q;
                sh_vld_q   <= 1'b0;
            end else if (accept && !cfg_bad) begin
                sh_h_q   <= cfg_h;
                sh_v_q   <= cfg_v;
                sh_pol_q <= cfg_pol_i;
                sh_vld_q <= 1'b1;
            end
        end
    end

    // Next raster position: park at the origin while disabled, else scan.
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (en_i) begin
            if (h_end) begin
                h_d = '0;
                v_d = v_end ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
                v_d = v_q;
            end
        end
    end

    // Raster counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Output decode of the position held this cycle; coordinates hold outside active video.
    always_comb begin
        de_d  = 1'b0;
        sof_d = 1'b0;
        eol_d = 1'b0;
        hs_d  = ~live_pol_q[0];
        vs_d  = ~live_pol_q[1];
        x_d   = x_q;
        y_d   = y_q;
        if (en_i) begin
            de_d  = in_hact && in_vact;
            sof_d = (h_q == '0) && (v_q == '0);
            eol_d = ((h_w + wide_t'(1)) == wide_t'(live_h_q.act)) && in_vact;
            hs_d  = in_hsync ? live_pol_q[0] : ~live_pol_q[0];
            vs_d  = in_vsync ? live_pol_q[1] : ~live_pol_q[1];
            if (in_hact && in_vact) begin
                x_d = h_q;
                y_d = v_q;
            end
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q  <= 1'b0;
            sof_q <= 1'b0;
            eol_q <= 1'b0;
            hs_q  <= ~POL_B;
            vs_q  <= ~POL_B;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            de_q  <= de_d;
            sof_q <= sof_d;
            eol_q <= eol_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign cfg_ready_o = ~sh_vld_q;
    assign cfg_pend_o  = sh_vld_q;
    assign cfg_err_o   = err_q;
    assign hsync_o     = hs_q;
    assign vsync_o     = vs_q;
    assign de_o        = de_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: per-cycle expected raster outputs
// are pushed to a scoreboard queue and popped after the following clock edge.
module tb_vga_timing_gen;

    localparam int CW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            en_i;
    logic            cfg_valid_i;
    logic            cfg_ready_o;
    logic [4*CW-1:0] cfg_h_i;
    logic [4*CW-1:0] cfg_v_i;
    logic [1:0]      cfg_pol_i;
    logic            cfg_err_o;
    logic            cfg_pend_o;
    logic            hsync_o;
    logic            vsync_o;
    logic            de_o;
    logic [CW-1:0]   x_o;
    logic [CW-1:0]   y_o;
    logic            sof_o;
    logic            eol_o;

    vga_timing_gen #(.CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_h_i     (cfg_h_i),
        .cfg_v_i     (cfg_v_i),
        .cfg_pol_i   (cfg_pol_i),
        .cfg_err_o   (cfg_err_o),
        .cfg_pend_o  (cfg_pend_o),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o),
        .de_o        (de_o),
        .x_o         (x_o),
        .y_o         (y_o),
        .sof_o       (sof_o),
        .eol_o       (eol_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          de;
        logic          hs;
        logic          vs;
        logic          sof;
        logic          eol;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } obs_t;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hp, vp;
    } tim_t;

    localparam tim_t T_DEF  = '{1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1, 1'b1};
    localparam tim_t T_CFG1 = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
    localparam tim_t T_CFG2 = '{5, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b1};
    localparam tim_t T_C1P0 = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};
    localparam tim_t T_BIG  = '{4000, 50, 40, 6, 3, 1, 1, 1, 1'b1, 1'b1};
    localparam tim_t T_NOSY = '{4, 1, 0, 1, 3, 1, 1, 1, 1'b1, 1'b1};
    localparam tim_t T_LONG = '{4000, 50, 40, 7, 3, 1, 1, 1, 1'b1, 1'b1};

    obs_t          sb_q[$];
    int unsigned   n_vec = 0;
    int unsigned   n_bad = 0;

    // Reference raster position and live timing as the spec describes them.
    tim_t          tm;
    int            mh, mv;
    logic [CW-1:0] mx, my;

    function automatic int tot_h(input tim_t t);
        return t.ha + t.hf + t.hs + t.hb;
    endfunction

    function automatic int tot_v(input tim_t t);
        return t.va + t.vf + t.vs + t.vb;
    endfunction

    function automatic logic at_wrap();
        return (mh == tot_h(tm) - 1) && (mv == tot_v(tm) - 1);
    endfunction

    task automatic drive_cfg(input tim_t t);
        cfg_h_i   = {CW'(t.ha), CW'(t.hf), CW'(t.hs), CW'(t.hb)};
        cfg_v_i   = {CW'(t.va), CW'(t.vf), CW'(t.vs), CW'(t.vb)};
        cfg_pol_i = {t.vp, t.hp};
    endtask

    // Expected registered outputs for one cycle, then advance the reference position.
    task automatic model_cycle(input logic en, output obs_t e);
        e.x = mx;
        e.y = my;
        if (!en) begin
            e.de  = 1'b0;
            e.sof = 1'b0;
            e.eol = 1'b0;
            e.hs  = !tm.hp;
            e.vs  = !tm.vp;
            mh = 0;
            mv = 0;
        end else begin
            e.de  = (mh < tm.ha) && (mv < tm.va);
            e.sof = (mh == 0) && (mv == 0);
            e.eol = (mh == tm.ha - 1) && (mv < tm.va);
            e.hs  = (mh >= tm.ha + tm.hf && mh < tm.ha + tm.hf + tm.hs) ? tm.hp : !tm.hp;
            e.vs  = (mv >= tm.va + tm.vf && mv < tm.va + tm.vf + tm.vs) ? tm.vp : !tm.vp;
            if (e.de) begin
                e.x = CW'(mh);
                e.y = CW'(mv);
                mx  = e.x;
                my  = e.y;
            end
            if (mh == tot_h(tm) - 1) begin
                mh = 0;
                mv = (mv == tot_v(tm) - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
    endtask

    function automatic obs_t sample();
        return {de_o, hsync_o, vsync_o, sof_o, eol_o, x_o, y_o};
    endfunction

    task automatic test_reset;
        obs_t got;
        rst = 1'b1;
        en_i = 1'b0;
        cfg_valid_i = 1'b0;
        drive_cfg(T_CFG1);
        repeat (2) @(posedge clk);
        #1;
        got = sample();
        n_vec++;
        if (got !== obs_t'(0)) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h want=%h", got, obs_t'(0));
        end
        n_vec++;
        if ({cfg_ready_o, cfg_pend_o, cfg_err_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_cfg_flags got ready/pend/err=%b want=100", {cfg_ready_o, cfg_pend_o, cfg_err_o});
        end
        tm = T_DEF;
        mh = 0;
        mv = 0;
        mx = '0;
        my = '0;
    endtask

    task automatic test_default_timing;
        obs_t e, got;
        int hs_cnt = 0;
        int hs_first = -1;
        for (int i = 0; i < 2060; i++) begin
            @(negedge clk);
            rst  = 1'b0;
            en_i = 1'b1;
            model_cycle(1'b1, e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL default_raster cyc=%0d got=%h want=%h", i, got, e);
            end
            if (hsync_o === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
        end
        n_vec++;
        if (hs_first != 2008) begin
            n_bad++;
            $display("FAIL default_hsync_start got=%0d want=2008", hs_first);
        end
        n_vec++;
        if (hs_cnt != 44) begin
            n_bad++;
            $display("FAIL default_hsync_width got=%0d want=44", hs_cnt);
        end
    endtask

    task automatic test_idle_apply;
        obs_t e, got;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            en_i = 1'b0;
            cfg_valid_i = (i == 0);
            drive_cfg(T_CFG1);
            model_cycle(1'b0, e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL idle_outputs cyc=%0d got=%h want=%h", i, got, e);
            end
            n_vec++;
            if ({cfg_ready_o, cfg_pend_o, cfg_err_o} !== ((i == 0) ? 3'b010 : 3'b100)) begin
                n_bad++;
                $display("FAIL idle_handshake cyc=%0d got ready/pend/err=%b", i, {cfg_ready_o, cfg_pend_o, cfg_err_o});
            end
        end
        tm = T_CFG1;
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            cfg_valid_i = 1'b0;
            en_i = 1'b1;
            model_cycle(1'b1, e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL small_frame cyc=%0d got=%h want=%h", i, got, e);
            end
        end
    endtask

    task automatic test_mid_frame;
        obs_t e, got;
        logic wrap;
        logic pend_exp = 1'b0;
        logic applied = 1'b0;
        int   post = 0;
        for (int i = 0; i < 200 && post < 44; i++) begin
            @(negedge clk);
            cfg_valid_i = (i == 10);
            drive_cfg(T_CFG2);
            wrap = at_wrap();
            model_cycle(1'b1, e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL midframe_raster cyc=%0d got=%h want=%h", i, got, e);
            end
            if (wrap && pend_exp) begin
                tm = T_CFG2;
                pend_exp = 1'b0;
                applied = 1'b1;
            end
            if (i == 10) pend_exp = 1'b1;
            n_vec++;
            if (cfg_pend_o !== pend_exp || cfg_ready_o !== !pend_exp) begin
                n_bad++;
                $display("FAIL midframe_pend cyc=%0d got pend=%b ready=%b want pend=%b", i, cfg_pend_o, cfg_ready_o, pend_exp);
            end
            if (applied) post++;
        end
        n_vec++;
        if (applied !== 1'b1) begin
            n_bad++;
            $display("FAIL midframe_apply_timeout got applied=%b want 1", applied);
        end
    endtask

    task automatic test_reject;
        obs_t e, got;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cfg_valid_i = (i == 2) || (i == 6);
            drive_cfg((i == 2) ? T_NOSY : T_LONG);
            model_cycle(1'b1, e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL reject_raster cyc=%0d got=%h want=%h", i, got, e);
            end
            n_vec++;
            if ({cfg_err_o, cfg_ready_o, cfg_pend_o} !== {(i == 2) || (i == 6), 2'b10}) begin
                n_bad++;
                $display("FAIL reject_flags cyc=%0d got err/ready/pend=%b want err=%b ready=1 pend=0",
                         i, {cfg_err_o, cfg_ready_o, cfg_pend_o}, (i == 2) || (i == 6));
            end
        end
    endtask

    task automatic test_back_to_back;
        obs_t e, got;
        logic wrap;
        logic pend_exp = 1'b0;
        logic offered = 1'b0;
        logic applied = 1'b0;
        int   off_i = -100;
        int   post = 0;
        for (int i = 0; i < 300 && post < 10; i++) begin
            @(negedge clk);
            wrap = at_wrap();
            cfg_valid_i = 1'b0;
            if (wrap && !offered) begin
                cfg_valid_i = 1'b1;
                drive_cfg(T_CFG1);
            end
            if (offered && i == off_i + 15) begin
                cfg_valid_i = 1'b1;
                drive_cfg(T_C1P0);
            end
            model_cycle(1'b1, e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL b2b_raster cyc=%0d got=%h want=%h", i, got, e);
            end
            if (wrap && pend_exp) begin
                tm = T_CFG1;
                pend_exp = 1'b0;
                applied = 1'b1;
                n_vec++;
                if (i - off_i != 40) begin
                    n_bad++;
                    $display("FAIL b2b_apply_delay got=%0d want=40", i - off_i);
                end
            end
            if (wrap && !offered) begin
                offered = 1'b1;
                off_i = i;
                pend_exp = 1'b1;
            end
            n_vec++;
            if ({cfg_pend_o, cfg_ready_o, cfg_err_o} !== {pend_exp, !pend_exp, 1'b0}) begin
                n_bad++;
                $display("FAIL b2b_flags cyc=%0d got pend/ready/err=%b want pend=%b", i, {cfg_pend_o, cfg_ready_o, cfg_err_o}, pend_exp);
            end
            if (applied) post++;
        end
        n_vec++;
        if (applied !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_apply_timeout got applied=%b want 1", applied);
        end
    endtask

    task automatic test_rst_midframe;
        obs_t e, got;
        logic reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mv == 2) begin
                reached = 1'b1;
                break;
            end
            cfg_valid_i = (i == 0);
            drive_cfg(T_BIG);
            model_cycle(1'b1, e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL rst_pre_raster cyc=%0d got=%h want=%h", i, got, e);
            end
            n_vec++;
            if ({cfg_pend_o, cfg_err_o} !== 2'b10) begin
                n_bad++;
                $display("FAIL big_cfg_accept cyc=%0d got pend/err=%b want 10", i, {cfg_pend_o, cfg_err_o});
            end
        end
        n_vec++;
        if (reached !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_line2_timeout got reached=%b want 1", reached);
            @(negedge clk);
        end
        rst = 1'b1;
        cfg_valid_i = 1'b0;
        @(posedge clk);
        #1;
        got = sample();
        n_vec++;
        if (got !== obs_t'(0) || {cfg_ready_o, cfg_pend_o, cfg_err_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL rst_midframe got=%h ready/pend/err=%b want=%h 100", got, {cfg_ready_o, cfg_pend_o, cfg_err_o}, obs_t'(0));
        end
        tm = T_DEF;
        mh = 0;
        mv = 0;
        mx = '0;
        my = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b0;
            en_i = 1'b0;
            cfg_valid_i = (i == 0);
            drive_cfg(T_C1P0);
            model_cycle(1'b0, e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL pol0_idle cyc=%0d got=%h want=%h", i, got, e);
            end
            if (i == 1) tm = T_C1P0;
        end
        n_vec++;
        if ({hsync_o, vsync_o} !== 2'b11) begin
            n_bad++;
            $display("FAIL pol0_syncs_idle got=%b want 11", {hsync_o, vsync_o});
        end
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            cfg_valid_i = 1'b0;
            en_i = 1'b1;
            model_cycle(1'b1, e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL pol0_frame cyc=%0d got=%h want=%h", i, got, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en_i = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_h_i = '0;
        cfg_v_i = '0;
        cfg_pol_i = '0;
        test_reset;
        test_default_timing;
        test_idle_apply;
        test_mid_frame;
        test_reject;
        test_back_to_back;
        test_rst_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
